// File: rtl/wb_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_queue_if
// Purpose  : Bundle of WB-stage/MDU requests, register-file write port and
//            decode-stage hazard/forwarding signals for wb_queue.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_queue_if #(
    parameter int DATA_W = 32
);
    logic              pipeValid;
    logic [4:0]        pipeReg;
    logic [DATA_W-1:0] pipeData;
    logic              mduValid;
    logic [4:0]        mduReg;
    logic [DATA_W-1:0] mduData;
    logic              mduReady;
    logic              regWrite;
    logic [4:0]        writeRegister;
    logic [DATA_W-1:0] writeData;
    logic [4:0]        readRegister1;
    logic [4:0]        readRegister2;
    logic              hazard1;
    logic              hazard2;
    logic              fwdValid1;
    logic              fwdValid2;
    logic [DATA_W-1:0] fwdData1;
    logic [DATA_W-1:0] fwdData2;

    modport slave (
        input  pipeValid, pipeReg, pipeData, mduValid, mduReg, mduData,
               readRegister1, readRegister2,
        output mduReady, regWrite, writeRegister, writeData,
               hazard1, hazard2, fwdValid1, fwdValid2, fwdData1, fwdData2
    );

    modport master (
        output pipeValid, pipeReg, pipeData, mduValid, mduReg, mduData,
               readRegister1, readRegister2,
        input  mduReady, regWrite, writeRegister, writeData,
               hazard1, hazard2, fwdValid1, fwdValid2, fwdData1, fwdData2
    );
endinterface
`default_nettype wire

// File: rtl/wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : wb_queue
// Purpose  : Writeback queue merging pipeline and MDU results into one
//            register-file write per cycle; optional forwarding (WB_FWD_EN).
// Revision : 1.0 - initial release
// ============================================================================
module wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    wb_queue_if.slave bus
);
    // DEPTH must be a power of two (>= 4) so pointers wrap by truncation.
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL      = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_MDU_LIMIT = c_CNT_W'(DEPTH - 2);

    logic [4:0]         r_reg  [DEPTH];
    logic [DATA_W-1:0]  r_data [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;

    logic               w_mdu_ready;
    logic               w_pipe_en;
    logic               w_mdu_en;
    logic               w_deq;
    logic [c_PTR_W-1:0] w_mdu_idx;
    logic               w_hit1;
    logic               w_hit2;

    // Keeping one slot free for the pipeline means it never needs back-pressure.
    always_comb begin
        w_mdu_ready = !rst && (r_count <= c_MDU_LIMIT);
        w_pipe_en   = bus.pipeValid && (bus.pipeReg != 5'd0);
        w_mdu_en    = bus.mduValid && w_mdu_ready && (bus.mduReg != 5'd0);
        w_deq       = (r_count != '0);
        w_mdu_idx   = r_tail + c_PTR_W'(w_pipe_en);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_deq) begin
                r_head <= r_head + c_PTR_W'(1);
            end
            r_tail  <= r_tail + c_PTR_W'(w_pipe_en) + c_PTR_W'(w_mdu_en);
            r_count <= r_count + c_CNT_W'(w_pipe_en) + c_CNT_W'(w_mdu_en)
                       - c_CNT_W'(w_deq);
        end
    end

    // Pipeline entry is older than a same-cycle MDU entry, so it goes first.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_pipe_en) begin
                r_reg[r_tail]  <= bus.pipeReg;
                r_data[r_tail] <= bus.pipeData;
            end
            if (w_mdu_en) begin
                r_reg[w_mdu_idx]  <= bus.mduReg;
                r_data[w_mdu_idx] <= bus.mduData;
            end
        end
    end

    function automatic logic f_hit(input logic [4:0] src);
        logic               hit;
        logic [c_PTR_W-1:0] idx;
        hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_head + c_PTR_W'(k);
            if ((c_CNT_W'(k) < r_count) && (r_reg[idx] == src) && (src != 5'd0)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    always_comb begin
        w_hit1 = f_hit(bus.readRegister1);
        w_hit2 = f_hit(bus.readRegister2);
    end

    assign bus.mduReady      = w_mdu_ready;
    assign bus.regWrite      = w_deq;
    assign bus.writeRegister = w_deq ? r_reg[r_head]  : 5'd0;
    assign bus.writeData     = w_deq ? r_data[r_head] : '0;
    assign bus.hazard1       = w_hit1;
    assign bus.hazard2       = w_hit2;

`ifdef WB_FWD_EN
    logic [DATA_W-1:0] w_fwd1;
    logic [DATA_W-1:0] w_fwd2;

    // Scanning oldest to youngest lets the youngest match win.
    function automatic logic [DATA_W-1:0] f_youngest(input logic [4:0] src);
        logic [DATA_W-1:0]  data;
        logic [c_PTR_W-1:0] idx;
        data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = r_head + c_PTR_W'(k);
            if ((c_CNT_W'(k) < r_count) && (r_reg[idx] == src) && (src != 5'd0)) begin
                data = r_data[idx];
            end
        end
        return data;
    endfunction

    always_comb begin
        w_fwd1 = f_youngest(bus.readRegister1);
        w_fwd2 = f_youngest(bus.readRegister2);
    end

    assign bus.fwdValid1 = w_hit1;
    assign bus.fwdValid2 = w_hit2;
    assign bus.fwdData1  = w_fwd1;
    assign bus.fwdData2  = w_fwd2;
`else
    assign bus.fwdValid1 = 1'b0;
    assign bus.fwdValid2 = 1'b0;
    assign bus.fwdData1  = '0;
    assign bus.fwdData2  = '0;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) r_count != c_FULL);

endmodule
`default_nettype wire

// File: tb/tb_wb_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_queue
// Purpose  : Self-checking bench for wb_queue: vector table, corner-case
//            sequences and random traffic against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_queue_if #(.DATA_W(DATA_W)) bus ();

    wb_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    typedef struct {
        logic pv; logic [4:0] pr; logic [31:0] pd;
        logic mv; logic [4:0] mr; logic [31:0] md;
        logic [4:0] r1; logic [4:0] r2;
        logic e_rw; logic [4:0] e_wr; logic [31:0] e_wd;
        logic e_mrdy; logic e_h1; logic e_h2; logic [31:0] e_f1;
    } vec_t;

    int   checks   = 0;
    int   failures = 0;
    ent_t q[$];
    ent_t sub[$];
    ent_t got[$];
    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [4:0] pr, input logic [31:0] pd,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic [4:0] r1, input logic [4:0] r2);
        @(negedge clk);
        rst               = 1'b0;
        bus.pipeValid     = pv;
        bus.pipeReg       = pr;
        bus.pipeData      = pd;
        bus.mduValid      = mv;
        bus.mduReg        = mr;
        bus.mduData       = md;
        bus.readRegister1 = r1;
        bus.readRegister2 = r2;
        #1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst           = 1'b1;
        bus.pipeValid = 1'b0;
        bus.mduValid  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    // Reference: outputs follow from the queue contents seen this cycle.
    task automatic mcheck(input string tag);
        logic        e_rw, e_h1, e_h2;
        logic [4:0]  e_wr;
        logic [31:0] e_wd, e_d1, e_d2;
        e_rw = (q.size() != 0);
        e_wr = e_rw ? q[0].r : 5'd0;
        e_wd = e_rw ? q[0].d : 32'd0;
        e_h1 = 1'b0; e_h2 = 1'b0; e_d1 = 32'd0; e_d2 = 32'd0;
        foreach (q[i]) begin
            if (bus.readRegister1 != 5'd0 && q[i].r == bus.readRegister1) begin
                e_h1 = 1'b1; e_d1 = q[i].d;
            end
            if (bus.readRegister2 != 5'd0 && q[i].r == bus.readRegister2) begin
                e_h2 = 1'b1; e_d2 = q[i].d;
            end
        end
        chk({tag, "_regWrite"}, 32'(bus.regWrite), 32'(e_rw));
        chk({tag, "_writeRegister"}, 32'(bus.writeRegister), 32'(e_wr));
        chk({tag, "_writeData"}, bus.writeData, e_wd);
        chk({tag, "_mduReady"}, 32'(bus.mduReady), 32'(q.size() <= DEPTH - 2));
        chk({tag, "_hazard1"}, 32'(bus.hazard1), 32'(e_h1));
        chk({tag, "_hazard2"}, 32'(bus.hazard2), 32'(e_h2));
        chk({tag, "_fwdValid1"}, 32'(bus.fwdValid1), 32'(FWD ? e_h1 : 1'b0));
        chk({tag, "_fwdValid2"}, 32'(bus.fwdValid2), 32'(FWD ? e_h2 : 1'b0));
        chk({tag, "_fwdData1"}, bus.fwdData1, FWD ? e_d1 : 32'd0);
        chk({tag, "_fwdData2"}, bus.fwdData2, FWD ? e_d2 : 32'd0);
    endtask

    task automatic mupdate();
        bit mr;
        mr = (q.size() <= DEPTH - 2);
        if (q.size() != 0) q.delete(0);
        if (bus.pipeValid && bus.pipeReg != 5'd0) q.push_back('{bus.pipeReg, bus.pipeData});
        if (bus.mduValid && mr && bus.mduReg != 5'd0) q.push_back('{bus.mduReg, bus.mduData});
    endtask

    task automatic step(input logic pv, input logic [4:0] pr, input logic [31:0] pd,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        input logic [4:0] r1, input logic [4:0] r2, input string tag);
        drive(pv, pr, pd, mv, mr, md, r1, r2);
        mcheck(tag);
        mupdate();
    endtask

    initial begin
        logic        pv, mpend, acc;
        logic [4:0]  pr, mreg, r1, r2;
        logic [31:0] pd, mdat;
        int          mid;

        bus.pipeValid = 1'b0; bus.pipeReg = 5'd0; bus.pipeData = 32'd0;
        bus.mduValid  = 1'b0; bus.mduReg  = 5'd0; bus.mduData  = 32'd0;
        bus.readRegister1 = 5'd0; bus.readRegister2 = 5'd0;

        //          pv    pr    pd        mv    mr    md      r1    r2    rw    wr    wd        mrdy  h1    h2    f1
        tbl[0]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b1, 5'd5, 32'h1234, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0};
        tbl[4]  = '{1'b1, 5'd3, 32'hA,    1'b1, 5'd4, 32'hB,  5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b1, 5'd3, 32'hA,    1'b1, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b1, 5'd4, 32'hB,    1'b1, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 5'd0, 32'h99,   1'b1, 5'd0, 32'h77, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd0, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 5'd7, 32'h1,    1'b1, 5'd7, 32'h2,  5'd7, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0};
        tbl[11] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd7, 5'd0, 1'b1, 5'd7, 32'h1,    1'b1, 1'b1, 1'b0, 32'h2};
        tbl[12] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd7, 5'd0, 1'b1, 5'd7, 32'h2,    1'b1, 1'b1, 1'b0, 32'h2};
        tbl[13] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,  5'd7, 5'd0, 1'b0, 5'd0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0};

        reset_dut();
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].pv, tbl[i].pr, tbl[i].pd, tbl[i].mv, tbl[i].mr, tbl[i].md, tbl[i].r1, tbl[i].r2);
            chk($sformatf("vec%0d_regWrite", i), 32'(bus.regWrite), 32'(tbl[i].e_rw));
            chk($sformatf("vec%0d_writeRegister", i), 32'(bus.writeRegister), 32'(tbl[i].e_wr));
            chk($sformatf("vec%0d_writeData", i), bus.writeData, tbl[i].e_wd);
            chk($sformatf("vec%0d_mduReady", i), 32'(bus.mduReady), 32'(tbl[i].e_mrdy));
            chk($sformatf("vec%0d_hazard1", i), 32'(bus.hazard1), 32'(tbl[i].e_h1));
            chk($sformatf("vec%0d_hazard2", i), 32'(bus.hazard2), 32'(tbl[i].e_h2));
            chk($sformatf("vec%0d_fwdValid1", i), 32'(bus.fwdValid1), 32'(FWD ? tbl[i].e_h1 : 1'b0));
            chk($sformatf("vec%0d_fwdData1", i), bus.fwdData1, FWD ? tbl[i].e_f1 : 32'd0);
        end

        // Saturation: both sources every cycle; MDU holds its offer until taken.
        reset_dut();
        mid = 0;
        for (int c = 0; c < 20; c++) begin
            pr   = 5'((c % 15) + 1);
            mreg = 5'((mid % 15) + 16);
            drive(1'b1, pr, 32'h1000 + c, 1'b1, mreg, 32'h2000 + mid, 5'd0, 5'd0);
            mcheck("sat");
            chk($sformatf("sat%0d_mduReady", c), 32'(bus.mduReady), 32'(c < 2));
            if (bus.regWrite) got.push_back('{bus.writeRegister, bus.writeData});
            sub.push_back('{pr, 32'h1000 + c});
            if (bus.mduReady) begin
                sub.push_back('{mreg, 32'h2000 + mid});
                mid++;
            end
            mupdate();
        end
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
            mcheck("drain");
            if (bus.regWrite) got.push_back('{bus.writeRegister, bus.writeData});
            mupdate();
        end
        chk("sat_write_count", 32'(got.size()), 32'(sub.size()));
        for (int i = 0; i < sub.size() && i < got.size(); i++) begin
            chk($sformatf("sat_order%0d", i), {got[i].r, got[i].d[26:0]}, {sub[i].r, sub[i].d[26:0]});
        end

        // Reset with three entries queued and an MDU offer during reset.
        reset_dut();
        step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd0, 5'd0, "pre");
        step(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0, "pre");
        @(negedge clk);
        rst = 1'b1;
        bus.pipeValid = 1'b0;
        bus.mduValid = 1'b1; bus.mduReg = 5'd6; bus.mduData = 32'h66;
        bus.readRegister1 = 5'd3; bus.readRegister2 = 5'd4;
        @(negedge clk);
        rst = 1'b0;
        bus.mduValid = 1'b0;
        #1;
        chk("rst_regWrite", 32'(bus.regWrite), 32'd0);
        chk("rst_hazard1", 32'(bus.hazard1), 32'd0);
        chk("rst_hazard2", 32'(bus.hazard2), 32'd0);
        chk("rst_mduReady", 32'(bus.mduReady), 32'd1);
        q.delete();
        mupdate();
        step(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "post");
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0, "post");
        chk("post_writeRegister", 32'(bus.writeRegister), 32'd9);
        chk("post_writeData", bus.writeData, 32'h99);

        // Random traffic with small register range to provoke hazards.
        reset_dut();
        mpend = 1'b0; mreg = 5'd0; mdat = 32'd0;
        for (int c = 0; c < 400; c++) begin
            pv = 1'($urandom_range(0, 1));
            pr = 5'($urandom_range(0, 7));
            pd = $urandom;
            if (!mpend && $urandom_range(0, 2) == 0) begin
                mpend = 1'b1;
                mreg  = 5'($urandom_range(0, 7));
                mdat  = $urandom;
            end
            r1 = 5'($urandom_range(0, 7));
            r2 = 5'($urandom_range(0, 7));
            drive(pv, pr, pd, mpend, mreg, mdat, r1, r2);
            mcheck("rnd");
            acc = mpend && (q.size() <= DEPTH - 2);
            mupdate();
            if (acc) mpend = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wb_queue.md
# wb_queue

Writeback queue for the MIPS core: collects register-write results from the main pipeline and the multi-cycle multiply/divide unit (MDU), orders them, and drives the register file's single write port at most one write per cycle. It sits between the WB stage / MDU and the register file, and reports pending writes back to decode so it can stall on hazards or forward data.

## Interface
- DEPTH, 4, queue entries; power of two, minimum 4
- DATA_W, 32, result width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- pipeValid  in  1  pipeline result valid this cycle; never back-pressured
- pipeReg  in  5  pipeline destination register
- pipeData  in  DATA_W  pipeline result
- mduValid  in  1  MDU result offered
- mduReg  in  5  MDU destination register
- mduData  in  DATA_W  MDU result
- mduReady  out  1  queue accepts MDU result this cycle
- regWrite  out  1  write enable to register file
- writeRegister  out  5  register file write address
- writeData  out  DATA_W  register file write data
- readRegister1, readRegister2  in  5 each  decode-stage source registers
- hazard1, hazard2  out  1 each  a queued write targets the matching source
- fwdValid1, fwdValid2  out  1 each  forwarding data valid (see Configuration)
- fwdData1, fwdData2  out  DATA_W each  forwarded value

## Operation
- Circular FIFO of DEPTH entries {reg, data}, head/tail pointers, count 0..DEPTH.
- Enqueue at posedge: pipeline entry if pipeValid; MDU entry if mduValid && mduReady. Both same cycle: pipeline entry written first (older), MDU entry behind it.
- Requests with destination 5'd0 are accepted but not enqueued (no entry, no regWrite); MDU handshake still completes.
- Dequeue: whenever count > 0, head is popped at every posedge; no stall input.
- regWrite = (count != 0); writeRegister/writeData = head entry; combinational from queue state.
- mduReady = (count <= DEPTH-2), from registered count. Guarantees a pipeline slot always exists; count never exceeds DEPTH-1. Overflow is unreachable; an assertion flags count == DEPTH.
- hazardN = (readRegisterN != 0) && any valid entry has reg == readRegisterN. Entries enqueued this cycle are not visible until next cycle.
- Forwarding: youngest matching valid entry supplies fwdDataN; fwdValidN = hazardN.

## Timing
- Reset: count, head, tail = 0; regWrite, mduReady-independent outputs, hazard*, fwdValid* = 0; writeRegister, writeData, fwdData* = 0 while empty.
- mduReady = 1 in the first cycle after reset.
- Latency: request accepted at edge N → regWrite high during cycle N..N+1 if queue was empty; register file captures it on the following negedge.
- Empty queue, pipeValid every cycle: one write per cycle, count stays 1.
- Pipe+MDU same cycle on empty queue: pipeline write in cycle after edge N, MDU write one cycle later.
- Pointer wrap: head/tail wrap modulo DEPTH with no lost or duplicated entries.
- rst asserted mid-operation: all queued writes discarded; regWrite = 0 in the cycle after the reset edge; an mduValid presented during reset is not accepted.

## Configuration
- WB_FWD_EN defined: forwarding logic built as above.
- WB_FWD_EN undefined: fwdValid1/2 and fwdData1/2 tied to 0; hazard outputs unchanged; decode must stall on hazard.

## Test plan
- Reset then pipeValid=1, pipeReg=5, pipeData=32'h1234 → next cycle regWrite=1, writeRegister=5, writeData=32'h1234; following cycle regWrite=0.
- Same edge pipe (r3, 32'hA) and MDU (r4, 32'hB) → writes r3=A then r4=B on consecutive cycles; mduReady stays 1.
- pipeValid with pipeReg=0 → regWrite never asserts; mduValid with mduReg=0 and mduReady=1 → accepted, no write.
- pipe and MDU valid every cycle for 20 cycles, DEPTH=4 → mduReady drops when count=3 (≥DEPTH-1), no entry lost, writes in submission order, count never 4, pointers wrap at least twice.
- Queue holds r7=1 then r7=2, readRegister1=7 → hazard1=1, fwdData1=2 with WB_FWD_EN, fwdValid1=0/fwdData1=0 without; readRegister2=0 → hazard2=0.
- Three entries queued, rst pulsed one cycle → regWrite=0, hazard*=0 after reset edge; next pipe request written normally.
